// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
// Optional memory ready handshake under MULTICYCLE_CTRL_MEM_READY_EN.
interface multicycle_control_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic [6:0]          opcode;
  logic                zero;
`ifdef MULTICYCLE_CTRL_MEM_READY_EN
  logic                mem_ready;
`endif
  logic                pc_write;
  logic                adr_src;
  logic                mem_write;
  logic                ir_write;
  logic [1:0]          result_sel;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                reg_write;
  logic                branch;
  logic                illegal_op;
  logic [RETIRE_W-1:0] instret;

  modport master (
    input  opcode, zero,
`ifdef MULTICYCLE_CTRL_MEM_READY_EN
    input  mem_ready,
`endif
    output pc_write, adr_src, mem_write, ir_write, result_sel,
    output alu_src_a, alu_src_b, alu_op, reg_write, branch,
    output illegal_op, instret
  );

  modport slave (
    output opcode, zero,
`ifdef MULTICYCLE_CTRL_MEM_READY_EN
    output mem_ready,
`endif
    input  pc_write, adr_src, mem_write, ir_write, result_sel,
    input  alu_src_a, alu_src_b, alu_op, reg_write, branch,
    input  illegal_op, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multicycle RV32I core plus retired-instruction counter.
// Define MULTICYCLE_CTRL_MEM_READY_EN to stall FETCH/MEM_RD/MEM_WR on mem_ready.
module multicycle_control #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master ctrl
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEM_RD = 4'd4;
  localparam logic [3:0] S_MEM_WB = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_EXEC_R = 4'd7;
  localparam logic [3:0] S_EXEC_I = 4'd8;
  localparam logic [3:0] S_JAL    = 4'd9;
  localparam logic [3:0] S_ALU_WB = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0]          state;
  logic [3:0]          state_nxt;
  logic                retire;
  logic                ready;
  logic [RETIRE_W-1:0] instret;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       branch;
  logic       illegal_op;

`ifdef MULTICYCLE_CTRL_MEM_READY_EN
  assign ready = ctrl.mem_ready;
`else
  assign ready = 1'b1;
`endif

  // State register; reset lands in IDLE so every output decodes to 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + RETIRE_W'(1);
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_sel = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd2;
        result_sel = 2'd2;
        if (ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        case (ctrl.opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_JAL:            state_nxt = S_JAL;
          OP_BRANCH:         state_nxt = S_BRANCH;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        state_nxt = (ctrl.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        adr_src = 1'b1;
        if (ready) begin
          state_nxt = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        result_sel = 2'd1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd0;
        alu_op    = 2'd2;
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        alu_op    = 2'd2;
        state_nxt = S_ALU_WB;
      end
      S_JAL: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd0;
        alu_op    = 2'd1;
        branch    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  assign ctrl.pc_write   = pc_write;
  assign ctrl.adr_src    = adr_src;
  assign ctrl.mem_write  = mem_write;
  assign ctrl.ir_write   = ir_write;
  assign ctrl.result_sel = result_sel;
  assign ctrl.alu_src_a  = alu_src_a;
  assign ctrl.alu_src_b  = alu_src_b;
  assign ctrl.alu_op     = alu_op;
  assign ctrl.reg_write  = reg_write;
  assign ctrl.branch     = branch;
  assign ctrl.illegal_op = illegal_op;
  assign ctrl.instret    = instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected outputs queued, checked at negedge.
module tb_multicycle_control;

  logic clk;
  logic rst_n;

  multicycle_control_if #(.RETIRE_W(32)) bus ();

  multicycle_control #(.RETIRE_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] vec;
    logic [31:0] ret;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          errors;
  logic [31:0] exp_ret;

  function automatic logic [14:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] op, input logic rw,
                                     input logic br, input logic ill);
    return {pcw, adr, mw, irw, rs, a, b, op, rw, br, ill};
  endfunction

  // Hand-derived output vectors per state: pcw adr mw irw rs a b op rw br ill
  localparam logic [14:0] V_IDLE    = 15'd0;
  logic [14:0] v_fetch, v_fetch_stall, v_decode, v_decode_ill, v_memadr, v_mem_rd;
  logic [14:0] v_mem_wb, v_mem_wr, v_exec_r, v_exec_i, v_jal, v_alu_wb, v_branch;

  initial begin
    v_fetch       = mk(1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 2'd0, 0, 0, 0);
    v_fetch_stall = mk(0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 0, 0);
    v_decode      = mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 0, 0, 0);
    v_decode_ill  = mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 0, 0, 1);
    v_memadr      = mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 0, 0, 0);
    v_mem_rd      = mk(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    v_mem_wb      = mk(0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 1, 0, 0);
    v_mem_wr      = mk(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    v_exec_r      = mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 0, 0);
    v_exec_i      = mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd2, 0, 0, 0);
    v_jal         = mk(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 0, 0);
    v_alu_wb      = mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0);
    v_branch      = mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1, 0, 1, 0);
  end

  // Monitor: every negedge with a pending expectation is one observed DUT cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [14:0] got;
      e   = q.pop_front();
      got = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_sel,
             bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.branch,
             bus.illegal_op};
      checks++;
      if (got !== e.vec) begin
        errors++;
        $display("FAIL %s outputs: got %b expected %b (pcw adr mw irw rs a b op rw br ill)",
                 e.name, got, e.vec);
      end
      checks++;
      if (bus.instret !== e.ret) begin
        errors++;
        $display("FAIL %s instret: got %0d expected %0d", e.name, bus.instret, e.ret);
      end
    end
  end

  task automatic step(input logic [14:0] v, input string nm);
    exp_t e;
    e.vec  = v;
    e.ret  = exp_ret;
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [6:0] op);
    bus.opcode = op;
    step(v_fetch, "FETCH");
    step(op == 7'b0000000 || op == 7'b0110111 ? v_decode_ill : v_decode, "DECODE");
  endtask

  task automatic run_r();
    fetch(7'b0110011);
    step(v_exec_r, "EXEC_R");
    step(v_alu_wb, "ALU_WB");
    exp_ret++;
  endtask

  task automatic run_i();
    fetch(7'b0010011);
    step(v_exec_i, "EXEC_I");
    step(v_alu_wb, "ALU_WB");
    exp_ret++;
  endtask

  task automatic run_load();
    fetch(7'b0000011);
    step(v_memadr, "MEMADR_LD");
    step(v_mem_rd, "MEM_RD");
    step(v_mem_wb, "MEM_WB");
    exp_ret++;
  endtask

  task automatic run_store();
    fetch(7'b0100011);
    step(v_memadr, "MEMADR_ST");
    step(v_mem_wr, "MEM_WR");
    exp_ret++;
  endtask

  task automatic run_jal();
    fetch(7'b1101111);
    step(v_jal, "JAL");
    step(v_alu_wb, "ALU_WB_JAL");
    exp_ret++;
  endtask

  task automatic run_branch(input logic z);
    bus.zero = z;
    fetch(7'b1100011);
    step(v_branch, "BRANCH");
    exp_ret++;
  endtask

  initial begin
    exp_t e;
    bus.opcode = 7'b0000000;
    bus.zero   = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_READY_EN
    bus.mem_ready = 1'b1;
`endif
    rst_n   = 1'b0;
    exp_ret = 32'd0;
    checks  = 0;
    errors  = 0;

    @(posedge clk);
    #1;
    step(V_IDLE, "RESET");
    rst_n = 1'b1;
    step(V_IDLE, "IDLE");

    run_r();
    run_load();
    run_store();
    run_i();
    run_branch(1'b1);
    run_jal();
    fetch(7'b0000000);
    fetch(7'b0110111);
    run_branch(1'b0);
    run_r();

`ifdef MULTICYCLE_CTRL_MEM_READY_EN
    // Fetch stalled three cycles, then a store whose write waits two cycles.
    bus.opcode    = 7'b0100011;
    bus.mem_ready = 1'b0;
    step(v_fetch_stall, "FETCH_STALL");
    step(v_fetch_stall, "FETCH_STALL");
    step(v_fetch_stall, "FETCH_STALL");
    bus.mem_ready = 1'b1;
    step(v_fetch, "FETCH_RDY");
    step(v_decode, "DECODE");
    step(v_memadr, "MEMADR_ST");
    bus.mem_ready = 1'b0;
    step(v_mem_wr, "MEM_WR_STALL");
    step(v_mem_wr, "MEM_WR_STALL");
    bus.mem_ready = 1'b1;
    step(v_mem_wr, "MEM_WR_RDY");
    exp_ret++;
    run_load();
`endif

    // Asynchronous reset in the middle of a store's MEM_WR cycle.
    fetch(7'b0100011);
    step(v_memadr, "MEMADR_ST");
    rst_n = 1'b0;
    #1;
    exp_ret  = 32'd0;
    e.vec    = V_IDLE;
    e.ret    = exp_ret;
    e.name   = "ASYNC_RST";
    q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(V_IDLE, "IDLE_AFTER_RST");
    run_r();
    step(v_fetch, "FETCH_END");

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multicycle RV32I core. It decodes the opcode latched in the instruction register and drives every datapath select and write strobe, including the 2-bit `result_sel` of the result mux/ALU-out register stage. It also maintains a retired-instruction counter. It sits between the instruction register and the datapath; `funct3`/`funct7` decoding is owned by the ALU decoder, which consumes `alu_op`.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  `instr[6:0]` from the instruction register.
- `zero`  in  1  ALU zero flag; forwarded only through `branch`, never evaluated here.
- `pc_write`  out  1  PC load strobe.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = result.
- `mem_write`  out  1  data memory write enable.
- `ir_write`  out  1  instruction register load strobe.
- `result_sel`  out  2  result mux select: 0 = registered ALU out, 1 = memory data, 2 = ALU result (direct).
- `alu_src_a`  out  2  ALU A select: 0 = PC, 1 = old PC, 2 = rs1.
- `alu_src_b`  out  2  ALU B select: 0 = rs2, 1 = immediate, 2 = constant 4.
- `alu_op`  out  2  ALU decoder class: 0 = add, 1 = subtract/compare, 2 = funct-decoded.
- `reg_write`  out  1  register file write enable.
- `branch`  out  1  conditional PC update; the datapath ANDs it with `zero`.
- `illegal_op`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `instret`  out  `RETIRE_W`  count of retired instructions.

## Operation
- The FSM is Moore: every output is a function of the state only, except the stall gating described under Configuration. Any output not listed for a state is 0.
- States, with their non-zero outputs and next state:
  - `IDLE`: no outputs. Next is `FETCH`. This is the reset state and is never re-entered.
  - `FETCH`: `ir_write`=1, `pc_write`=1, `alu_src_a`=0, `alu_src_b`=2, `result_sel`=2. Next is `DECODE`.
  - `DECODE`: `alu_src_a`=1, `alu_src_b`=1, which computes the branch/jump target. Next state depends on `opcode`:
    - 0000011 or 0100011 → `MEMADR`.
    - 0110011 → `EXEC_R`.
    - 0010011 → `EXEC_I`.
    - 1101111 → `JAL`.
    - 1100011 → `BRANCH`.
    - any other opcode → `FETCH`, with `illegal_op`=1 in that `DECODE` cycle.
  - `MEMADR`: `alu_src_a`=2, `alu_src_b`=1. Next is `MEM_RD` if `opcode` is 0000011, otherwise `MEM_WR`.
  - `MEM_RD`: `adr_src`=1, `result_sel`=0. Next is `MEM_WB`.
  - `MEM_WB`: `result_sel`=1, `reg_write`=1. Next is `FETCH`, and the instruction retires.
  - `MEM_WR`: `adr_src`=1, `result_sel`=0, `mem_write`=1. Next is `FETCH`, and the instruction retires.
  - `EXEC_R`: `alu_src_a`=2, `alu_src_b`=0, `alu_op`=2. Next is `ALU_WB`.
  - `EXEC_I`: `alu_src_a`=2, `alu_src_b`=1, `alu_op`=2. Next is `ALU_WB`.
  - `JAL`: `alu_src_a`=1, `alu_src_b`=2, `result_sel`=0, `pc_write`=1. Next is `ALU_WB`.
  - `ALU_WB`: `result_sel`=0, `reg_write`=1. Next is `FETCH`, and the instruction retires.
  - `BRANCH`: `alu_src_a`=2, `alu_src_b`=0, `alu_op`=1, `result_sel`=0, `branch`=1. Next is `FETCH`, and the instruction retires.
- `instret` increments by 1 on the clock edge that leaves a retiring state. It wraps modulo 2^`RETIRE_W`. Illegal opcodes do not retire.
- `opcode` is sampled only in `DECODE` and `MEMADR`. The IR is stable in both because `ir_write` is asserted only in `FETCH`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state is `IDLE`;
  - every strobe is 0 and every select is 0;
  - `instret` is 0.
- The first `FETCH` occurs one cycle after `rst_n` deasserts.
- Reset asserted in any state aborts the instruction immediately: no pending `reg_write` or `mem_write` is issued and `instret` is not incremented.
- Latency in cycles from `FETCH` to the return to `FETCH`, with no stalls:
  - load: 5
  - store: 4
  - R-type and I-type: 4
  - JAL: 4
  - branch: 3
  - illegal opcode: 2
- `result_sel`=0 relies on the ALU-out register having captured the previous state's ALU result. Every state that selects 0 is immediately preceded by a state that computes the value.

## Configuration
- Macro `MULTICYCLE_CTRL_MEM_READY_EN`.
- Defined:
  - Adds input port `mem_ready` (1 bit).
  - `FETCH`, `MEM_RD` and `MEM_WR` hold their state while `mem_ready`=0.
  - In `FETCH`, `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1.
  - `mem_write` stays high throughout `MEM_WR`.
  - Retirement from `MEM_WR` happens only on the ready cycle.
- Undefined: the port does not exist and memory is single-cycle; behaviour is as above.

## Test plan
- Reset release, then `opcode`=0110011 (add) → states IDLE, FETCH, DECODE, EXEC_R, ALU_WB, FETCH. `reg_write`=1 only in ALU_WB with `result_sel`=0. `instret` goes 0→1.
- Load (`opcode`=0000011) → exactly 5 cycles. `MEM_RD` has `adr_src`=1. `MEM_WB` has `result_sel`=1 and `reg_write`=1. `instret`+1.
- Store (`opcode`=0100011) → `mem_write`=1 for exactly one cycle, `reg_write` never asserts, 4 cycles total.
- Branch (`opcode`=1100011), then JAL (`opcode`=1101111):
  - branch: `branch`=1 and `alu_op`=1 in one cycle;
  - JAL: `pc_write`=1 in both FETCH and the JAL state.
- `opcode`=0000000 → `illegal_op` pulses once in DECODE, the next state is FETCH, and `instret` is unchanged. Separately, `rst_n` pulsed low during `MEM_WR` → outputs are 0 asynchronously and `instret` is 0.
- With `MULTICYCLE_CTRL_MEM_READY_EN` defined and `mem_ready` low for 3 cycles in FETCH → `ir_write`/`pc_write` stay 0 for those 3 cycles, then go to 1 for one cycle, then DECODE.
